// File: rtl/seq_mult.sv
// seq_mult: radix-2 shift-add multiplier for signed or unsigned operands.
// The latency is fixed at WIDTH+1 cycles from accept to out_valid, with a valid/ready handshake on both sides.
module seq_mult #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic               i_is_signed,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [2*WIDTH-1:0] o_product,
    output logic               o_busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             r_state, w_next;
    logic [2*WIDTH-1:0] r_mcand, r_acc, r_product, w_acc_next;
    logic [WIDTH-1:0]   r_mplier, w_mag_a, w_mag_b;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg, r_out_valid, w_accept, w_last, w_out_hs;

    assign w_accept   = i_in_valid && (r_state == IDLE);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_out_hs   = r_out_valid && i_out_ready;
    // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude
    assign w_mag_a    = (i_is_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_mag_b    = (i_is_signed && i_b[WIDTH-1]) ? -i_b : i_b;
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    assign o_in_ready  = (r_state == IDLE);
    assign o_busy      = (r_state != IDLE);
    assign o_out_valid = r_out_valid;
    assign o_product   = r_product;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CALC;
            CALC:    if (w_last)   w_next = DONE;
            DONE:    if (w_out_hs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                r_mplier <= w_mag_b;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_neg    <= i_is_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            end else if (r_state == CALC) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (w_last) r_product <= r_neg ? -w_acc_next : w_acc_next;
            end
            // valid rises one cycle after entering DONE, giving the WIDTH+1 latency
            r_out_valid <= (r_state == DONE) && !w_out_hs;
        end
    end
endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: scoreboard bench for seq_mult.
// It runs directed WIDTH=16 cases plus a WIDTH=8 random stream with handshake jitter on both sides.
module tb_seq_mult;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        v16 = 1'b0, s16 = 1'b0, ord16 = 1'b0, rdy16, ov16, busy16;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] prod16;
    logic        v8 = 1'b0, s8 = 1'b0, ord8 = 1'b0, rdy8, ov8, busy8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] prod8;
    logic [31:0] q16[$];
    logic [15:0] q8[$];
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    seq_mult #(.WIDTH(16)) u16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(v16), .o_in_ready(rdy16),
        .i_a(a16), .i_b(b16), .i_is_signed(s16), .o_out_valid(ov16),
        .i_out_ready(ord16), .o_product(prod16), .o_busy(busy16)
    );

    seq_mult #(.WIDTH(8)) u8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(v8), .o_in_ready(rdy8),
        .i_a(a8), .i_b(b8), .i_is_signed(s8), .o_out_valid(ov8),
        .i_out_ready(ord8), .o_product(prod8), .o_busy(busy8)
    );

    function automatic logic [31:0] exp16(input logic [15:0] a, input logic [15:0] b, input logic s);
        return s ? 32'($signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b})) : {16'd0, a} * {16'd0, b};
    endfunction

    function automatic logic [15:0] exp8(input logic [7:0] a, input logic [7:0] b, input logic s);
        return s ? 16'($signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b})) : {8'd0, a} * {8'd0, b};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic s);
        int n;
        n = 0;
        a16 = a; b16 = b; s16 = s; v16 = 1'b1;
        while (!rdy16 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        v16 = 1'b0;
        check("accept16", 64'(n < 100), 1);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s, input int hold, input bit scr);
        int n;
        logic [31:0] p;
        q16.push_back(exp16(a, b, s));
        start16(a, b, s);
        n = 0;
        while (!ov16 && n < 100) begin
            if (scr) begin
                a16 = 16'($urandom); b16 = 16'($urandom); s16 = ~s16;
            end
            @(posedge clk); #1; n++;
        end
        check("latency16", n, 17);
        p = prod16;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold16", {ov16, rdy16, prod16}, {1'b1, 1'b0, p});
        end
        ord16 = 1'b1;
        @(posedge clk); #1;
        ord16 = 1'b0;
        check("product16", p, q16.pop_front());
        check("release16", {ov16, rdy16, busy16}, 3'b010);
    endtask

    initial begin
        bit abort;
        #1 rst_n = 1'b0;
        #1;
        check("reset_state", {rdy16, ov16, busy16, prod16}, {3'b100, 32'd0});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run16(16'd15, 16'd30, 1'b0, 0, 0);
        run16(16'hFFFF, 16'hFFFF, 1'b0, 0, 0);
        run16(16'h8000, 16'h8000, 1'b1, 0, 0);
        run16(16'hFFFD, 16'd5, 1'b1, 0, 0);
        run16(16'h8000, 16'h7FFF, 1'b1, 0, 0);
        run16(16'd0, 16'd0, 1'b1, 0, 0);
        run16(16'd0, 16'h1234, 1'b0, 0, 0);
        run16(16'h1234, 16'h5678, 1'b1, 10, 1);

        start16(16'd100, 16'd200, 1'b0);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {rdy16, ov16, busy16, prod16}, {3'b100, 32'd0});
        @(posedge clk); #1 rst_n = 1'b1;
        run16(16'd3, 16'd4, 1'b0, 0, 0);

        abort = 0;
        fork
            begin
                for (int i = 0; i < 2000 && !abort; i++) begin
                    logic [7:0] a, b;
                    logic s;
                    int n;
                    a = ($urandom_range(7) == 0) ? 8'h80 : 8'($urandom);
                    b = ($urandom_range(7) == 0) ? 8'h80 : 8'($urandom);
                    s = 1'($urandom);
                    while ($urandom_range(3) == 0) begin
                        @(posedge clk); #1;
                    end
                    a8 = a; b8 = b; s8 = s; v8 = 1'b1; n = 0;
                    while (!rdy8 && n < 100) begin
                        @(posedge clk); #1; n++;
                    end
                    if (n >= 100) begin
                        check("accept8", n, 0);
                        abort = 1;
                    end else begin
                        q8.push_back(exp8(a, b, s));
                        @(posedge clk); #1;
                    end
                    v8 = 1'b0;
                    a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
                end
            end
            begin
                int got, cyc;
                got = 0; cyc = 0;
                while (got < 2000 && cyc < 80000 && !abort) begin
                    ord8 = 1'($urandom);
                    if (ov8 && ord8) begin
                        if (q8.size() == 0) check("dup8", 1, 0);
                        else check("rand8", prod8, q8.pop_front());
                        got++;
                    end
                    @(posedge clk); #1; cyc++;
                end
                ord8 = 1'b0;
                check("count8", got, 2000);
            end
        join
        check("q8_empty", q8.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
